// File: rtl/mdu_issue_ctrl.sv
// Issue control for the multi-cycle multiply/divide unit: stalls, launches, revokes and completes MDU ops.
// Optional MDU_LATENCY_CHECK_EN adds a sticky latency_error when the unit's count_down disagrees with cnt.
module mdu_issue_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] op,
    input  logic       flush,
    input  logic       mdu_busy,
    input  logic [3:0] mdu_count_down,
    output logic       in_ready,
    output logic [4:0] ctrl,
    output logic       calculate,
    output logic       revoke,
    output logic       load_HI,
    output logic       load_LO,
    output logic       mdu_active,
    output logic       latency_error,
    output logic [3:0] dbg_cnt
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       is_mdu;
    logic       running;
    logic       accept;

    // Handshake: an MDU-class op (in_valid with op 1..8) is taken in the cycle where
    // in_valid && in_ready && !flush; in_ready drops only for MDU-class ops while RUN or mdu_busy.
    always_comb begin
        is_mdu     = in_valid && (op >= OP_MULT) && (op <= OP_MTLO);
        running    = (state == RUN);
        in_ready   = reset && !(is_mdu && (running || mdu_busy));
        accept     = is_mdu && in_ready && !flush;
        revoke     = reset && running && flush;
        calculate  = reset && running && (cnt == 4'd1) && !flush;
        mdu_active = reset && running;
        dbg_cnt    = reset ? cnt : 4'd0;
    end

    always_comb begin
        ctrl    = 5'b00000;
        load_HI = 1'b0;
        load_LO = 1'b0;
        if (accept) begin
            case (op)
                OP_MULT:  ctrl = 5'b10000;
                OP_MULTU: ctrl = 5'b10100;
                OP_DIV:   ctrl = 5'b11000;
                OP_DIVU:  ctrl = 5'b11100;
                OP_MFHI:  ctrl = 5'b00010;
                OP_MFLO:  ctrl = 5'b00011;
                OP_MTHI: begin
                    ctrl    = 5'b00010;
                    load_HI = 1'b1;
                end
                OP_MTLO: begin
                    ctrl    = 5'b00011;
                    load_LO = 1'b1;
                end
                default:  ctrl = 5'b00000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl[4]) begin
                        state <= RUN;
                        cnt   <= ctrl[3] ? DIV_LOAD : MULT_LOAD;
                    end
                end
                RUN: begin
                    // A flush cancels the calculation even in its final cycle.
                    if (flush || (cnt == 4'd1)) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef MDU_LATENCY_CHECK_EN
    logic lat_err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_err_q <= 1'b0;
        end else if (running && (mdu_count_down != cnt)) begin
            lat_err_q <= 1'b1;
        end
    end

    assign latency_error = reset && lat_err_q;
`else
    logic unused_count_down;

    assign unused_count_down = ^mdu_count_down;
    assign latency_error     = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: a small multiply-unit model drives mdu_busy/count_down,
// a negedge monitor checks every strobe event (cycle-stamped) against a queue of expected events.
module tb_mdu_issue_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] OP_MULT = 4'd1;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_DIVU = 4'd4;
    localparam logic [3:0] OP_MFHI = 4'd5;
    localparam logic [3:0] OP_MFLO = 4'd6;
    localparam logic [3:0] OP_MTHI = 4'd7;
    localparam logic [3:0] OP_MTLO = 4'd8;

    // Event word: {ctrl[4:0], calculate, revoke, load_HI, load_LO}
    localparam logic [8:0] EV_MULT = 9'b10000_0000;
    localparam logic [8:0] EV_DIV  = 9'b11000_0000;
    localparam logic [8:0] EV_DIVU = 9'b11100_0000;
    localparam logic [8:0] EV_MFHI = 9'b00010_0000;
    localparam logic [8:0] EV_MFLO = 9'b00011_0000;
    localparam logic [8:0] EV_MTHI = 9'b00010_0010;
    localparam logic [8:0] EV_MTLO = 9'b00011_0001;
    localparam logic [8:0] EV_CALC = 9'b00000_1000;
    localparam logic [8:0] EV_REVK = 9'b00000_0100;

`ifdef MDU_LATENCY_CHECK_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 0;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] op;
    logic       flush;
    logic       mdu_busy;
    logic [3:0] mdu_count_down;
    logic       in_ready;
    logic [4:0] ctrl;
    logic       calculate;
    logic       revoke;
    logic       load_HI;
    logic       load_LO;
    logic       mdu_active;
    logic       latency_error;
    logic [3:0] dbg_cnt;

    logic [3:0] mdu_cd;
    logic       busy_force;
    logic       cd_force_en;
    logic [3:0] cd_force;

    int n_checks;
    int n_err;
    int cyc;
    int t0;
    int t1;

    logic [24:0] exp_q[$];

    mdu_issue_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .op             (op),
        .flush          (flush),
        .mdu_busy       (mdu_busy),
        .mdu_count_down (mdu_count_down),
        .in_ready       (in_ready),
        .ctrl           (ctrl),
        .calculate      (calculate),
        .revoke         (revoke),
        .load_HI        (load_HI),
        .load_LO        (load_LO),
        .mdu_active     (mdu_active),
        .latency_error  (latency_error),
        .dbg_cnt        (dbg_cnt)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiply-unit model: loads its latency on launch and counts down to zero
    always @(posedge clk) begin
        if (!reset) begin
            mdu_cd <= 4'd0;
        end else if (ctrl[4]) begin
            mdu_cd <= ctrl[3] ? 4'(DIV_N) : 4'(MULT_N);
        end else if (mdu_cd != 4'd0) begin
            mdu_cd <= mdu_cd - 4'd1;
        end
    end

    assign mdu_busy       = (mdu_cd != 4'd0) || busy_force;
    assign mdu_count_down = cd_force_en ? cd_force : mdu_cd;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int at, input logic [8:0] ev);
        logic [15:0] at16;
        at16 = at[15:0];
        exp_q.push_back({at16, ev});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic f);
        in_valid = v;
        op       = o;
        flush    = f;
    endtask

    // Monitor: every cycle with any strobe set must match the head of the expected queue
    always @(negedge clk) begin
        logic [8:0]  evt;
        logic [24:0] e;
        logic [15:0] c16;
        evt = {ctrl, calculate, revoke, load_HI, load_LO};
        c16 = cyc[15:0];
        if (evt != 9'd0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got evt=%b at cycle %0d expected no event", evt, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({c16, evt} !== e) begin
                    n_err++;
                    $display("FAIL event: got evt=%b at cycle %0d expected evt=%b at cycle %0d",
                             evt, cyc, e[8:0], e[24:9]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_err       = 0;
        reset       = 1'b0;
        busy_force  = 1'b0;
        cd_force_en = 1'b0;
        cd_force    = 4'd0;
        drive(1'b1, OP_MULT, 1'b0);

        // Reset: everything low even with a launchable op presented
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_ctrl", int'(ctrl), 0);
        check("rst_active", int'(mdu_active), 0);
        check("rst_lat_err", int'(latency_error), 0);
        nxt();
        reset = 1'b1;
        drive(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        check("idle_ready", int'(in_ready), 1);
        check("idle_cnt", int'(dbg_cnt), 0);

        // mult then mflo stalled until the calculate cycle has passed
        nxt();
        drive(1'b1, OP_MULT, 1'b0);
        t0 = cyc;
        expect_evt(t0, EV_MULT);
        expect_evt(t0 + MULT_N, EV_CALC);
        expect_evt(t0 + MULT_N + 1, EV_MFLO);
        @(negedge clk);
        check("mult_ready", int'(in_ready), 1);
        nxt();
        drive(1'b1, OP_MFLO, 1'b0);
        for (int k = 1; k <= MULT_N; k++) begin
            @(negedge clk);
            check("mflo_stall", int'(in_ready), 0);
            check("mult_active", int'(mdu_active), 1);
            if (k == 1) check("mult_cnt_load", int'(dbg_cnt), MULT_N);
            nxt();
        end
        @(negedge clk);
        check("mflo_ready", int'(in_ready), 1);
        check("mult_done_idle", int'(mdu_active), 0);
        nxt();
        drive(1'b0, 4'd0, 1'b0);

        // divu: active for exactly DIV_N cycles
        nxt();
        drive(1'b1, OP_DIVU, 1'b0);
        t0 = cyc;
        expect_evt(t0, EV_DIVU);
        expect_evt(t0 + DIV_N, EV_CALC);
        nxt();
        drive(1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= DIV_N; k++) begin
            @(negedge clk);
            check("divu_active", int'(mdu_active), 1);
            nxt();
        end
        @(negedge clk);
        check("divu_done_idle", int'(mdu_active), 0);

        // div flushed on its last cycle, then a mult held off by mdu_busy
        nxt();
        drive(1'b1, OP_DIV, 1'b0);
        t0 = cyc;
        expect_evt(t0, EV_DIV);
        expect_evt(t0 + DIV_N, EV_REVK);
        nxt();
        drive(1'b0, 4'd0, 1'b0);
        repeat (DIV_N - 1) nxt();
        drive(1'b0, 4'd0, 1'b1);
        @(negedge clk);
        check("flush_cnt", int'(dbg_cnt), 1);
        check("flush_revoke", int'(revoke), 1);
        check("flush_no_calc", int'(calculate), 0);
        nxt();
        busy_force = 1'b1;
        drive(1'b1, OP_MULT, 1'b0);
        @(negedge clk);
        check("revoke_idle", int'(mdu_active), 0);
        check("drain_stall", int'(in_ready), 0);
        nxt();
        nxt();
        @(negedge clk);
        check("drain_stall2", int'(in_ready), 0);
        nxt();
        busy_force = 1'b0;
        t1 = cyc;
        expect_evt(t1, EV_MULT);
        expect_evt(t1 + MULT_N, EV_CALC);
        @(negedge clk);
        check("drain_release", int'(in_ready), 1);
        nxt();
        drive(1'b0, 4'd0, 1'b0);
        repeat (MULT_N) nxt();

        // Moves in IDLE, flushed move, ignored op under busy
        drive(1'b1, OP_MTHI, 1'b0);
        expect_evt(cyc, EV_MTHI);
        @(negedge clk);
        check("mthi_ready", int'(in_ready), 1);
        check("mthi_load_hi", int'(load_HI), 1);
        check("mthi_load_lo", int'(load_LO), 0);
        nxt();
        drive(1'b1, OP_MTLO, 1'b1);
        @(negedge clk);
        check("mtlo_flush_strobes", int'({ctrl, calculate, revoke, load_HI, load_LO}), 0);
        nxt();
        drive(1'b1, OP_MTLO, 1'b0);
        expect_evt(cyc, EV_MTLO);
        nxt();
        drive(1'b1, OP_MFHI, 1'b0);
        expect_evt(cyc, EV_MFHI);
        nxt();
        busy_force = 1'b1;
        drive(1'b1, 4'd9, 1'b0);
        @(negedge clk);
        check("op9_ready_busy", int'(in_ready), 1);
        nxt();
        drive(1'b1, OP_MFHI, 1'b0);
        @(negedge clk);
        check("mfhi_busy_stall", int'(in_ready), 0);
        nxt();
        drive(1'b0, OP_MFHI, 1'b0);
        @(negedge clk);
        check("novalid_ready", int'(in_ready), 1);
        nxt();
        busy_force = 1'b0;
        drive(1'b0, 4'd0, 1'b0);

        // Reset in the middle of a mult (cnt=3)
        nxt();
        drive(1'b1, OP_MULT, 1'b0);
        t0 = cyc;
        expect_evt(t0, EV_MULT);
        nxt();
        drive(1'b0, 4'd0, 1'b0);
        nxt();
        nxt();
        check("pre_reset_cnt", int'(dbg_cnt), 3);
        reset = 1'b0;
        drive(1'b1, OP_MFHI, 1'b0);
        @(negedge clk);
        check("midrst_ready", int'(in_ready), 0);
        check("midrst_active", int'(mdu_active), 0);
        nxt();
        @(negedge clk);
        check("midrst_ready2", int'(in_ready), 0);
        nxt();
        reset = 1'b1;
        drive(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        check("postrst_active", int'(mdu_active), 0);
        check("postrst_cnt", int'(dbg_cnt), 0);
        repeat (4) nxt();

        // count_down disagreement while cnt=4
        drive(1'b1, OP_DIVU, 1'b0);
        t0 = cyc;
        expect_evt(t0, EV_DIVU);
        expect_evt(t0 + DIV_N, EV_CALC);
        nxt();
        drive(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        check("lat_match", int'(latency_error), 0);
        repeat (6) nxt();
        cd_force_en = 1'b1;
        cd_force    = 4'd7;
        @(negedge clk);
        check("lat_force_cnt", int'(dbg_cnt), 4);
        nxt();
        cd_force_en = 1'b0;
        @(negedge clk);
        check("lat_set", int'(latency_error), EXP_LAT);
        repeat (4) nxt();
        @(negedge clk);
        check("lat_sticky", int'(latency_error), EXP_LAT);
        nxt();
        reset = 1'b0;
        nxt();
        reset = 1'b1;
        @(negedge clk);
        check("lat_cleared", int'(latency_error), 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) nxt();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, is the mult/multu latency in cycles (1..15) and SHALL match the multiply unit's count_down load value.
REQ-002 Parameter DIV_CYCLES, default 10, is the div/divu latency in cycles (1..15) and SHALL match the multiply unit's count_down load value.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; 0 = reset asserted.
REQ-005 in_valid  input  1  an instruction occupies the issuing stage.
REQ-006 op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 are treated as none.
REQ-007 flush  input  1  the issuing-stage instruction and any in-flight calculation are cancelled.
REQ-008 mdu_busy  input  1  the multiply unit's busy output.
REQ-009 mdu_count_down  input  4  the multiply unit's count_down output.
REQ-010 in_ready  output  1  the issuing stage may advance; low = stall.
REQ-011 ctrl  output  5  multiply-unit ctrl: [0] LO target, [1] move mode, [2] unsigned, [3] divide, [4] launch.
REQ-012 calculate, revoke, load_HI, load_LO  output  1 each  multiply-unit strobes.
REQ-013 mdu_active  output  1  high while the state is RUN.
REQ-014 latency_error  output  1  sticky mismatch flag; see REQ-031.

Function
REQ-015 The block SHALL be a two-state FSM, IDLE/RUN, with a 4-bit counter cnt.
REQ-016 MDU-class means in_valid=1 and op is in 1..8; any other op is ignored and never stalled.
REQ-017 in_ready SHALL be 0 when the op is MDU-class and (state=RUN or mdu_busy=1); otherwise it SHALL be 1.
REQ-018 Accept means an MDU-class op with in_ready=1 and flush=0; ctrl, load_HI, and load_LO SHALL be combinational and nonzero only in an accept cycle.
REQ-019 Accept of mult/multu/div/divu SHALL drive ctrl[4]=1, ctrl[3]=div|divu, ctrl[2]=multu|divu, and ctrl[1:0]=0; at the clock edge the state SHALL go to RUN with cnt=MULT_CYCLES or DIV_CYCLES.
REQ-020 Accept of mfhi/mflo SHALL drive ctrl[1]=1 and ctrl[0]=(mflo), with no load and no state change.
REQ-021 Accept of mthi/mtlo SHALL drive ctrl[1]=1, ctrl[0]=(mtlo), load_HI=(mthi), and load_LO=(mtlo), with no state change.
REQ-022 In RUN, cnt SHALL decrement by 1 each cycle.
REQ-023 calculate SHALL be 1 exactly in the RUN cycle where cnt=1 and flush=0; at that edge the state SHALL go to IDLE with cnt=0.
REQ-024 Latency: with accept at cycle T, calculate SHALL occur at T+MULT_CYCLES or T+DIV_CYCLES, and the next MDU-class op SHALL be accepted no earlier than the following cycle.
REQ-025 A flush in RUN SHALL make revoke=1 for that cycle, suppress calculate, and at the edge set the state to IDLE with cnt=0.
REQ-026 If flush and cnt=1 occur together, flush SHALL win: revoke=1 and calculate=0.
REQ-027 A flush in IDLE SHALL drop the op: ctrl=0, no load, and revoke=0.
REQ-028 After a revoke, stalling SHALL continue via mdu_busy until the multiply unit drains.
REQ-029 revoke, calculate, and ctrl[4] SHALL be mutually exclusive in any cycle.

Reset
REQ-030 While reset=0, the state SHALL become IDLE, cnt=0, and latency_error=0, and every output, including in_ready, SHALL be 0.

Configuration
REQ-031 With MDU_LATENCY_CHECK_EN defined, latency_error SHALL set whenever state=RUN and mdu_count_down!=cnt, and SHALL clear only on reset.
REQ-032 Without MDU_LATENCY_CHECK_EN defined, latency_error SHALL be tied to 0 and no compare logic SHALL exist.

Verification
REQ-033 mult accepted at cycle 0 -> ctrl=5'b10000 at cycle 0; in_ready=0 for a following mflo during cycles 1-5; calculate at cycle 5; mflo accepted at cycle 6 with ctrl=5'b00011.
REQ-034 divu accepted at cycle 0 -> ctrl=5'b11100; calculate only at cycle 10; mdu_active high for cycles 1-10.
REQ-035 div accepted, then flush at cycle 10 (cnt=1) -> revoke=1, calculate=0, next state IDLE; a following mult stalls until mdu_busy=0.
REQ-036 mthi in IDLE -> load_HI=1, load_LO=0, ctrl=5'b00010, in_ready=1; mtlo with flush=1 -> all strobes 0.
REQ-037 reset=0 asserted mid-RUN (cnt=3) -> the next cycle has state IDLE, calculate never fires, and in_ready=0 while reset=0.
REQ-038 With MDU_LATENCY_CHECK_EN defined, force mdu_count_down=7 while cnt=4 in RUN -> latency_error=1 and it stays 1 until reset.
